// File: rtl/afifo_pkg.sv
// Shared defaults and packing convention for the AFIFO read-side packer.
package afifo_pkg;

  localparam int unsigned AFIFO_WIDTH = 12;
  localparam int unsigned PACK_WIDTH  = 16;

  // The first FIFO word popped lands in the least-significant bits of a packed word.
  localparam bit PACK_LSB_FIRST = 1'b1;

endpackage

// File: rtl/afifo_read_packer.sv
// Drains an AFIFO read port and repacks InWidth-bit words into OutWidth-bit
// words (LSB-first) on a valid/ready stream, with a zero-padded flush.
module afifo_read_packer
  import afifo_pkg::*;
#(
  parameter int unsigned InWidth  = AFIFO_WIDTH,
  parameter int unsigned OutWidth = PACK_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                fifoRead,
  input  logic [InWidth-1:0]  fifoData,
  input  logic                fifoEmpty,
  output logic [OutWidth-1:0] outData,
  output logic                outValid,
  input  logic                outReady,
  input  logic                flush,
  output logic                flushDone
);

  localparam int unsigned AccW = InWidth + OutWidth - 1;
  localparam int unsigned CntW = $clog2(InWidth + OutWidth);

  // Elaboration guards for configurations the datapath does not support.
  if (InWidth > OutWidth) begin : g_bad_width
    $error("afifo_read_packer: InWidth must not exceed OutWidth");
  end
  if (!PACK_LSB_FIRST) begin : g_bad_order
    $error("afifo_read_packer: only LSB-first packing is implemented");
  end

  logic [AccW-1:0]     acc_q, acc_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                flush_pend_q, flush_pend_d;
  logic [OutWidth-1:0] out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                flush_done_q, flush_done_d;

  logic                slot_free;
  logic [CntW-1:0]     cnt_sum;
  logic                fits;
  logic [AccW-1:0]     merged;

  assign slot_free = ~out_valid_q | outReady;
  assign cnt_sum   = cnt_q + CntW'(InWidth);
  assign fits      = (cnt_sum < CntW'(OutWidth));
  assign merged    = acc_q | (AccW'(fifoData) << cnt_q);

  // Pop strobe; held low during reset, while a flush is in progress, and when
  // a completing pop would have nowhere to put its output word.
  assign fifoRead = rst_n & ~fifoEmpty & ~flush_pend_q & ~flush & (slot_free | fits);

  // Next-state: pop/pack path, flush path and output-register handshake.
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q | flush;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q & ~outReady;
    flush_done_d = 1'b0;

    if (fifoRead) begin
      if (fits) begin
        acc_d = merged;
        cnt_d = cnt_sum;
      end else begin
        out_data_d  = merged[OutWidth-1:0];
        out_valid_d = 1'b1;
        acc_d       = merged >> OutWidth;
        cnt_d       = cnt_sum - CntW'(OutWidth);
      end
    end else if (flush_pend_q) begin
      if (cnt_q == '0) begin
        flush_pend_d = 1'b0;
        flush_done_d = 1'b1;
      end else if (slot_free) begin
        // acc is always zero above cnt, so the low slice is already zero-padded.
        out_data_d   = acc_q[OutWidth-1:0];
        out_valid_d  = 1'b1;
        acc_d        = '0;
        cnt_d        = '0;
        flush_pend_d = 1'b0;
        flush_done_d = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign outData   = out_data_q;
  assign outValid  = out_valid_q;
  assign flushDone = flush_done_q;

endmodule

// File: tb/tb_afifo_read_packer.sv
// Randomized and directed bench for afifo_read_packer against a bit-queue model.
module tb_afifo_read_packer;

  localparam int unsigned IW = 12;
  localparam int unsigned OW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifoRead;
  logic [IW-1:0] fifoData;
  logic          fifoEmpty;
  logic [OW-1:0] outData;
  logic          outValid;
  logic          outReady;
  logic          flush;
  logic          flushDone;

  afifo_read_packer #(.InWidth(IW), .OutWidth(OW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifoRead  (fifoRead),
    .fifoData  (fifoData),
    .fifoEmpty (fifoEmpty),
    .outData   (outData),
    .outValid  (outValid),
    .outReady  (outReady),
    .flush     (flush),
    .flushDone (flushDone)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Model: FIFO contents, consumed bit stream, expected packed words.
  logic [IW-1:0] src_q[$];
  bit            bitq[$];
  logic [OW-1:0] exp_words[$];
  bit            gap_en     = 1'b0;
  bit            ready_rand = 1'b0;
  bit            flush_req  = 1'b0;
  bit            flush_model = 1'b0;
  int            fd_seen = 0;
  int            fd_exp  = 0;

  // Per-cycle observations for directed timing checks.
  logic          rd_seen;
  logic          ov_seen;
  logic [OW-1:0] od_seen;
  logic          fd_now;

  task automatic pulse_flush(input bit modelled);
    flush_req   = 1'b1;
    flush_model = modelled;
  endtask

  // One clock: drive at negedge, observe before and after the rising edge.
  task automatic cycle();
    logic          pop_now, hs_now, fl_now;
    logic [OW-1:0] hs_data, wd;
    logic [IW-1:0] w;
    @(negedge clk);
    fifoEmpty = (src_q.size() == 0) || (gap_en && ($urandom_range(99) < 35));
    fifoData  = (src_q.size() != 0) ? src_q[0] : IW'($urandom);
    if (ready_rand) outReady = ($urandom_range(99) < 60);
    flush     = flush_req;
    fl_now    = flush_req & flush_model;
    flush_req = 1'b0;
    #1;
    pop_now = fifoRead;
    rd_seen = fifoRead;
    hs_now  = outValid & outReady;
    hs_data = outData;
    if (fifoEmpty) begin
      vec_cnt++;
      if (fifoRead !== 1'b0) begin
        err_cnt++;
        $display("FAIL read_while_empty got=%b required=0", fifoRead);
      end
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    if (hs_now === 1'b1) begin
      vec_cnt++;
      if (exp_words.size() == 0) begin
        err_cnt++;
        $display("FAIL word_unexpected got=%h required=none", hs_data);
      end else begin
        wd = exp_words.pop_front();
        if (hs_data !== wd) begin
          err_cnt++;
          $display("FAIL word_data got=%h required=%h", hs_data, wd);
        end
      end
    end
    if (pop_now === 1'b1 && src_q.size() != 0) begin
      w = src_q.pop_front();
      for (int i = 0; i < IW; i++) bitq.push_back(w[i]);
      while (bitq.size() >= OW) begin
        for (int i = 0; i < OW; i++) wd[i] = bitq.pop_front();
        exp_words.push_back(wd);
      end
    end
    if (fl_now) begin
      fd_exp++;
      if (bitq.size() != 0) begin
        wd = '0;
        for (int i = 0; i < bitq.size(); i++) wd[i] = bitq[i];
        exp_words.push_back(wd);
        bitq.delete();
      end
    end
    ov_seen = outValid;
    od_seen = outData;
    fd_now  = flushDone;
    if (flushDone === 1'b1) fd_seen++;
  endtask

  // Run with a free sink until everything queued has come out.
  task automatic drain();
    int n = 0;
    outReady = 1'b1; ready_rand = 1'b0; gap_en = 1'b0;
    while ((src_q.size() != 0 || exp_words.size() != 0 || outValid === 1'b1) && n < 300) begin
      cycle();
      n++;
    end
    repeat (3) cycle();
    vec_cnt++;
    if (n >= 300) begin
      err_cnt++;
      $display("FAIL drain_timeout got=%0d required<300 cycles (words left %0d)", n, exp_words.size());
    end
    vec_cnt++;
    if (fd_seen !== fd_exp) begin
      err_cnt++;
      $display("FAIL flush_done_count got=%0d required=%0d", fd_seen, fd_exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fifoEmpty = 1'b0; fifoData = 12'hABC; outReady = 1'b1; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++;
    if ({outValid, flushDone, fifoRead} !== 3'b000) begin
      err_cnt++;
      $display("FAIL reset_ctrl got=%b required=000", {outValid, flushDone, fifoRead});
    end
    vec_cnt++;
    if (outData !== 16'h0000) begin
      err_cnt++;
      $display("FAIL reset_data got=%h required=0000", outData);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [OW-1:0] exp_d [3];
    bit            exp_v;
    exp_d = '{16'hFABC, 16'h23DE, 16'h4561};
    outReady = 1'b1;
    src_q = '{12'hABC, 12'hDEF, 12'h123, 12'h456};
    for (int c = 0; c < 5; c++) begin
      cycle();
      exp_v = (c >= 1 && c <= 3);
      vec_cnt++;
      if (ov_seen !== exp_v) begin
        err_cnt++;
        $display("FAIL stream_valid[%0d] got=%b required=%b", c, ov_seen, exp_v);
      end
      if (exp_v) begin
        vec_cnt++;
        if (od_seen !== exp_d[c-1]) begin
          err_cnt++;
          $display("FAIL stream_data[%0d] got=%h required=%h", c, od_seen, exp_d[c-1]);
        end
      end
    end
  endtask

  task automatic test_flush_phase0();
    src_q = '{12'h111, 12'h222};
    pulse_flush(1'b1);
    cycle();
    vec_cnt++;
    if ({rd_seen, fd_now} !== 2'b00) begin
      err_cnt++;
      $display("FAIL phase0_flush_cycle got=%b required=00 (read,done)", {rd_seen, fd_now});
    end
    cycle();
    vec_cnt++;
    if ({rd_seen, fd_now, ov_seen} !== 3'b010) begin
      err_cnt++;
      $display("FAIL phase0_done got=%b required=010 (read,done,valid)", {rd_seen, fd_now, ov_seen});
    end
    cycle();
    cycle();
    vec_cnt++;
    if ({ov_seen, od_seen} !== {1'b1, 16'h2111}) begin
      err_cnt++;
      $display("FAIL phase0_restart got=%b/%h required=1/2111", ov_seen, od_seen);
    end
    pulse_flush(1'b1);
    drain();
  endtask

  task automatic test_flush_residual();
    outReady = 1'b1;
    src_q = '{12'hABC, 12'hDEF};
    cycle();
    cycle();
    pulse_flush(1'b1);
    cycle();
    vec_cnt++;
    if ({ov_seen, fd_now} !== 2'b00) begin
      err_cnt++;
      $display("FAIL residual_pending got=%b required=00 (valid,done)", {ov_seen, fd_now});
    end
    cycle();
    vec_cnt++;
    if ({ov_seen, fd_now, od_seen} !== {2'b11, 16'h00DE}) begin
      err_cnt++;
      $display("FAIL residual_load got=%b%b/%h required=11/00de", ov_seen, fd_now, od_seen);
    end
    src_q = '{12'h111, 12'h222};
    cycle();
    cycle();
    vec_cnt++;
    if ({ov_seen, od_seen} !== {1'b1, 16'h2111}) begin
      err_cnt++;
      $display("FAIL residual_restart got=%b/%h required=1/2111", ov_seen, od_seen);
    end
    pulse_flush(1'b1);
    drain();
  endtask

  task automatic test_backpressure();
    int pops = 0;
    outReady = 1'b1;
    src_q = '{12'hABC, 12'hDEF, 12'h123, 12'h456};
    cycle();
    cycle();
    outReady = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      pops += int'(rd_seen);
      vec_cnt++;
      if ({ov_seen, od_seen} !== {1'b1, 16'hFABC}) begin
        err_cnt++;
        $display("FAIL bp_hold[%0d] got=%b/%h required=1/fabc", c, ov_seen, od_seen);
      end
    end
    vec_cnt++;
    if (pops > 1 || rd_seen !== 1'b0) begin
      err_cnt++;
      $display("FAIL bp_stall got=%0d pops,last read %b required<=1 pops,last read 0", pops, rd_seen);
    end
    drain();
  endtask

  task automatic test_flush_absorb();
    outReady = 1'b1;
    src_q = '{12'hABC, 12'hDEF};
    cycle();
    cycle();
    outReady = 1'b0;
    pulse_flush(1'b1);
    cycle();
    pulse_flush(1'b0);
    cycle();
    cycle();
    vec_cnt++;
    if (fd_seen !== fd_exp - 1) begin
      err_cnt++;
      $display("FAIL absorb_early_done got=%0d required=%0d", fd_seen, fd_exp - 1);
    end
    outReady = 1'b1;
    cycle();
    vec_cnt++;
    if ({ov_seen, fd_now, od_seen} !== {2'b11, 16'h00DE}) begin
      err_cnt++;
      $display("FAIL absorb_load got=%b%b/%h required=11/00de", ov_seen, fd_now, od_seen);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    outReady = 1'b0;
    src_q = '{12'hABC, 12'hDEF};
    cycle();
    cycle();
    rst_n = 1'b0;
    src_q = '{12'h111, 12'h222};
    fifoEmpty = 1'b0;
    fifoData  = 12'h111;
    bitq.delete();
    exp_words.delete();
    #1;
    vec_cnt++;
    if ({outValid, fifoRead, outData} !== {2'b00, 16'h0000}) begin
      err_cnt++;
      $display("FAIL reset_async got=%b%b/%h required=00/0000", outValid, fifoRead, outData);
    end
    cycle();
    cycle();
    vec_cnt++;
    if ({rd_seen, ov_seen} !== 2'b00) begin
      err_cnt++;
      $display("FAIL reset_hold got=%b required=00 (read,valid)", {rd_seen, ov_seen});
    end
    rst_n = 1'b1;
    outReady = 1'b1;
    cycle();
    cycle();
    vec_cnt++;
    if ({ov_seen, od_seen} !== {1'b1, 16'h2111}) begin
      err_cnt++;
      $display("FAIL reset_restart got=%b/%h required=1/2111", ov_seen, od_seen);
    end
    pulse_flush(1'b1);
    drain();
  endtask

  task automatic test_random_gaps();
    int n = 0;
    for (int i = 0; i < 64; i++) src_q.push_back(IW'($urandom));
    gap_en = 1'b1;
    ready_rand = 1'b1;
    while (src_q.size() != 0 && n < 3000) begin
      if (fd_seen == fd_exp && $urandom_range(99) < 3) pulse_flush(1'b1);
      cycle();
      n++;
    end
    vec_cnt++;
    if (n >= 3000) begin
      err_cnt++;
      $display("FAIL random_timeout got=%0d words left required=0", src_q.size());
    end
    pulse_flush(1'b1);
    drain();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_flush_phase0();
    test_flush_residual();
    test_backpressure();
    test_flush_absorb();
    test_reset_mid();
    test_random_gaps();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
